// File: rtl/branch_rs.sv
// ---------------------------------------------------------------------------
// branch_rs -- reservation station for beq branches.
//
// Holds up to DEPTH dispatched branches, wakes their operands from the common
// data bus, and issues the oldest branch whose operands are both available.
// The issue outputs go to the branch checker through registers, and the
// strobe lasts one cycle.
//
// Optional feature macro: BRANCH_RS_BYPASS_EN
//   defined   : a dispatched operand that is still waiting can capture a CDB
//               broadcast made in the same cycle.
//   undefined : dispatch is refused in any cycle with cdb_valid=1, so that a
//               broadcast is never missed by an entry that is being written.
//
// Parameters
//   DEPTH   number of entries (power of two, 2..8)
//   TAG_W   ROB tag width
//   DATA_W  operand width
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   disp_valid / disp_ready   dispatch handshake
//   disp_rob_tag              ROB tag of the dispatched branch
//   disp_rs{1,2}_rdy/_val     operand value, or the producer tag in the low
//                             TAG_W bits when the ready bit is clear
//   cdb_valid/cdb_tag/cdb_data  result broadcast
//   flush                     misprediction flush, empties the station
//   branch_valid_instruction  one-cycle issue strobe
//   beq_rs1_data/beq_rs2_data/tag  issued operands and ROB tag, held between
//                             issues
// ---------------------------------------------------------------------------
module branch_rs #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [TAG_W-1:0]  disp_rob_tag,
  input  logic              disp_rs1_rdy,
  input  logic              disp_rs2_rdy,
  input  logic [DATA_W-1:0] disp_rs1_val,
  input  logic [DATA_W-1:0] disp_rs2_val,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              branch_valid_instruction,
  output logic [DATA_W-1:0] beq_rs1_data,
  output logic [DATA_W-1:0] beq_rs2_data,
  output logic [TAG_W-1:0]  tag
);

  // Entry storage.
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  rs1Rdy_q, rs1Rdy_d;
  logic [DEPTH-1:0]  rs2Rdy_q, rs2Rdy_d;
  logic [TAG_W-1:0]  robTag_q [DEPTH];
  logic [TAG_W-1:0]  robTag_d [DEPTH];
  logic [TAG_W-1:0]  rs1Tag_q [DEPTH];
  logic [TAG_W-1:0]  rs1Tag_d [DEPTH];
  logic [TAG_W-1:0]  rs2Tag_q [DEPTH];
  logic [TAG_W-1:0]  rs2Tag_d [DEPTH];
  logic [DATA_W-1:0] rs1Val_q [DEPTH];
  logic [DATA_W-1:0] rs1Val_d [DEPTH];
  logic [DATA_W-1:0] rs2Val_q [DEPTH];
  logic [DATA_W-1:0] rs2Val_d [DEPTH];

  // Relative-age matrix: older_q[i][j] = 1 means entry i was dispatched
  // before entry j. When an entry is written, its row is cleared and its
  // column is set. The matrix always gives a strict order among busy
  // entries, however often they are recycled.
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];

  // Registered issue outputs. The strobe register also acts as the issue-gap
  // flag.
  logic              strobe_q;
  logic [DATA_W-1:0] outRs1_q;
  logic [DATA_W-1:0] outRs2_q;
  logic [TAG_W-1:0]  outTag_q;

  logic [DEPTH-1:0]  dispOneHot;
  logic              freeAny;
  logic              dispAccept;
  logic              bypass1;
  logic              bypass2;
  logic              dispRs1Rdy;
  logic              dispRs2Rdy;
  logic [DATA_W-1:0] dispRs1Val;
  logic [DATA_W-1:0] dispRs2Val;

  logic [DEPTH-1:0]  eligible;
  logic [DEPTH-1:0]  issueSel;
  logic              issueFire;
  logic [DATA_W-1:0] selRs1;
  logic [DATA_W-1:0] selRs2;
  logic [TAG_W-1:0]  selTag;

  // Pick the lowest-index free entry. Occupancy is taken from the start of
  // the cycle, so an entry freed by this cycle's issue is not reused yet.
  always_comb begin
    dispOneHot = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        dispOneHot = '0;
        dispOneHot[i] = 1'b1;
      end
    end
  end

  assign freeAny = |(~busy_q);

`ifdef BRANCH_RS_BYPASS_EN
  // A waiting operand can pick up a broadcast made in the same cycle as its
  // dispatch.
  assign bypass1    = ~disp_rs1_rdy & cdb_valid & (cdb_tag == disp_rs1_val[TAG_W-1:0]);
  assign bypass2    = ~disp_rs2_rdy & cdb_valid & (cdb_tag == disp_rs2_val[TAG_W-1:0]);
  assign disp_ready = freeAny;
`else
  // Without the bypass path, dispatch waits out any broadcast cycle.
  assign bypass1    = 1'b0;
  assign bypass2    = 1'b0;
  assign disp_ready = freeAny & ~cdb_valid;
`endif

  assign dispAccept = disp_valid & disp_ready & ~flush;
  assign dispRs1Rdy = disp_rs1_rdy | bypass1;
  assign dispRs2Rdy = disp_rs2_rdy | bypass2;
  assign dispRs1Val = bypass1 ? cdb_data : disp_rs1_val;
  assign dispRs2Val = bypass2 ? cdb_data : disp_rs2_val;

  // Issue selection: an eligible entry wins when it is older than every other
  // eligible entry. No issue is made while the strobe is high or during a
  // flush.
  always_comb begin
    eligible = busy_q & rs1Rdy_q & rs2Rdy_q;
    issueSel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issueSel[i] = eligible[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && eligible[j] && !older_q[i][j]) begin
          issueSel[i] = 1'b0;
        end
      end
    end
    issueFire = ~strobe_q & ~flush & (|issueSel);
  end

  // Operand and tag multiplexer for the selected entry.
  always_comb begin
    selRs1 = '0;
    selRs2 = '0;
    selTag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issueSel[i]) begin
        selRs1 = selRs1 | rs1Val_q[i];
        selRs2 = selRs2 | rs2Val_q[i];
        selTag = selTag | robTag_q[i];
      end
    end
  end

  // Next-state of the entries, in this order: CDB wakeup, issue free,
  // dispatch write, age update, and finally flush, which overrides them all.
  always_comb begin
    busy_d   = busy_q;
    rs1Rdy_d = rs1Rdy_q;
    rs2Rdy_d = rs2Rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      robTag_d[i] = robTag_q[i];
      rs1Tag_d[i] = rs1Tag_q[i];
      rs2Tag_d[i] = rs2Tag_q[i];
      rs1Val_d[i] = rs1Val_q[i];
      rs2Val_d[i] = rs2Val_q[i];
      older_d[i]  = older_q[i];
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && busy_q[i] && !rs1Rdy_q[i] && (rs1Tag_q[i] == cdb_tag)) begin
        rs1Rdy_d[i] = 1'b1;
        rs1Val_d[i] = cdb_data;
      end
      if (cdb_valid && busy_q[i] && !rs2Rdy_q[i] && (rs2Tag_q[i] == cdb_tag)) begin
        rs2Rdy_d[i] = 1'b1;
        rs2Val_d[i] = cdb_data;
      end

      if (issueFire && issueSel[i]) begin
        busy_d[i] = 1'b0;
      end

      if (dispAccept && dispOneHot[i]) begin
        busy_d[i]   = 1'b1;
        robTag_d[i] = disp_rob_tag;
        rs1Rdy_d[i] = dispRs1Rdy;
        rs2Rdy_d[i] = dispRs2Rdy;
        rs1Val_d[i] = dispRs1Val;
        rs2Val_d[i] = dispRs2Val;
        rs1Tag_d[i] = disp_rs1_val[TAG_W-1:0];
        rs2Tag_d[i] = disp_rs2_val[TAG_W-1:0];
      end

      for (int j = 0; j < DEPTH; j++) begin
        if (dispAccept) begin
          if (dispOneHot[i]) begin
            older_d[i][j] = 1'b0;
          end else if (dispOneHot[j]) begin
            older_d[i][j] = 1'b1;
          end
        end
      end
    end

    if (flush) begin
      busy_d = '0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      rs1Rdy_q <= '0;
      rs2Rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        robTag_q[i] <= '0;
        rs1Tag_q[i] <= '0;
        rs2Tag_q[i] <= '0;
        rs1Val_q[i] <= '0;
        rs2Val_q[i] <= '0;
        older_q[i]  <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      rs1Rdy_q <= rs1Rdy_d;
      rs2Rdy_q <= rs2Rdy_d;
      for (int i = 0; i < DEPTH; i++) begin
        robTag_q[i] <= robTag_d[i];
        rs1Tag_q[i] <= rs1Tag_d[i];
        rs2Tag_q[i] <= rs2Tag_d[i];
        rs1Val_q[i] <= rs1Val_d[i];
        rs2Val_q[i] <= rs2Val_d[i];
        older_q[i]  <= older_d[i];
      end
    end
  end

  // Issue output registers. Reset clears them asynchronously, which also
  // cuts off a strobe that is in flight. The data outputs load only on an
  // issue, so they hold the last issued values between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
      outRs1_q <= '0;
      outRs2_q <= '0;
      outTag_q <= '0;
    end else begin
      strobe_q <= issueFire;
      if (issueFire) begin
        outRs1_q <= selRs1;
        outRs2_q <= selRs2;
        outTag_q <= selTag;
      end
    end
  end

  assign branch_valid_instruction = strobe_q;
  assign beq_rs1_data             = outRs1_q;
  assign beq_rs2_data             = outRs2_q;
  assign tag                      = outTag_q;

endmodule

// File: doc/branch_rs.md
BRANCH_RS -- requirements
Module: branch_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of reservation-station entries (power of two, 2..8).
REQ-002 SHALL have parameter TAG_W, default 3: ROB tag width.
REQ-003 SHALL have parameter DATA_W, default 32: operand width.
REQ-004 clk  input  1  the design's one clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 disp_valid  input  1  a beq is offered for dispatch this cycle.
REQ-007 disp_ready  output  1  the station accepts a dispatch this cycle.
REQ-008 disp_rob_tag  input  TAG_W  ROB tag of the dispatched branch.
REQ-009 disp_rs1_rdy, disp_rs2_rdy  input  1 each  operand value is already available.
REQ-010 disp_rs1_val, disp_rs2_val  input  DATA_W each  operand value, or the producer ROB tag in bits [TAG_W-1:0] when not ready.
REQ-011 cdb_valid  input  1  result broadcast on the common data bus.
REQ-012 cdb_tag  input  TAG_W  and  cdb_data  input  DATA_W  broadcast producer tag and value.
REQ-013 flush  input  1  misprediction flush from the ROB.
REQ-014 branch_valid_instruction  output  1  one-cycle issue strobe to the branch checker.
REQ-015 beq_rs1_data, beq_rs2_data  output  DATA_W each  issued operands.
REQ-016 tag  output  TAG_W  ROB tag of the issued branch.

Function
REQ-017 Each entry SHALL hold busy, rob tag, and per-operand ready/value/waiting-tag fields, plus an age stamp.
REQ-018 disp_ready SHALL be 1 when at least one entry is free, based on occupancy at cycle start; an entry freed by issue is not reusable in the same cycle.
REQ-019 A dispatch with disp_valid=1 and disp_ready=0 SHALL be ignored, leaving all state unchanged.
REQ-020 An accepted dispatch SHALL write the lowest-index free entry and stamp it youngest.
REQ-021 On cdb_valid, every busy, non-ready operand whose waiting tag equals cdb_tag SHALL capture cdb_data and become ready at the next edge.
REQ-022 An entry SHALL become issue-eligible when busy and both operands are ready.
REQ-023 Issue selection SHALL pick the oldest eligible entry, by dispatch order.
REQ-024 An entry selected in cycle n SHALL drive registered outputs with branch_valid_instruction=1 for exactly cycle n+1, and its entry SHALL be freed at the cycle-n edge.
REQ-025 No issue SHALL occur in the cycle following an issue, so the strobe is never high in two consecutive cycles and every issue presents a fresh rising edge.
REQ-026 beq_rs1_data, beq_rs2_data and tag SHALL hold their last issued values while the strobe is low.
REQ-027 flush=1 SHALL clear every busy bit at the next edge, suppress any issue selection that cycle, and take priority over a simultaneous dispatch.
REQ-028 A CDB match and an issue of the same entry in the same cycle SHALL NOT occur, because issue uses only operands already marked ready.
REQ-029 Age stamps SHALL remain correct with DEPTH entries continuously recycled, with no wrap ambiguity (relative-age matrix or saturating counters).

Reset
REQ-030 While rst=1, all busy bits SHALL be 0, branch_valid_instruction=0, beq_rs1_data=0, beq_rs2_data=0, tag=0, and the issue-gap flag SHALL be clear.
REQ-031 disp_ready SHALL be 1 after reset deasserts.
REQ-032 Reset asserted mid-operation SHALL abort a pending issue strobe immediately (asynchronously).

Configuration
REQ-033 With BRANCH_RS_BYPASS_EN defined, a dispatched non-ready operand whose tag matches a same-cycle cdb_tag with cdb_valid=1 SHALL capture cdb_data at dispatch.
REQ-034 Without BRANCH_RS_BYPASS_EN, disp_ready SHALL be 0 in any cycle with cdb_valid=1, so no wakeup is missed.

Verification
REQ-035 Ready dispatch: dispatch tag=2, rs1=5, rs2=5, both ready -> strobe high exactly one cycle, 2 cycles later, with beq_rs1_data=5, beq_rs2_data=5, tag=2.
REQ-036 Wakeup: dispatch tag=1, rs1 waiting on tag 4, rs2=7; then CDB tag=4, data=7 -> issue the following cycle with rs1=7.
REQ-037 Ordering and gap: fill 4 entries (tags 0..3), all ready -> issues in order 0,1,2,3, with the strobe low between each; disp_ready=0 while full; a fifth dispatch is dropped.
REQ-038 Flush: 3 entries busy, flush with a simultaneous dispatch -> no strobe afterwards, all entries free, the dispatched branch not stored.
REQ-039 Bypass: dispatch rs2 waiting on tag 6 with CDB tag=6, data=9 in the same cycle -> with BRANCH_RS_BYPASS_EN, issue with rs2=9; without it, disp_ready=0 that cycle and the dispatch retries.
REQ-040 Reset mid-issue: assert rst while the strobe is high -> all outputs 0 immediately, disp_ready=1 after release.
